// File: rtl/game_session_ctrl.sv
// -----------------------------------------------------------------------------
// game_session_ctrl
//
// Session controller for the Tetris top level. Turns PS/2 scan codes and
// per-player game-over flags into the menu cursor, the selected mode, a
// three-digit pre-game countdown, a one-cycle start pulse, a run enable and
// the index of the losing player.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_key        current scan code, 0 means no key pressed
//   i_game_over  per-player game-over level flags
//   o_state      0 IDLE, 1 COUNT, 2 PLAY, 3 PAUSE, 4 OVER
//   o_cursor     highlighted menu entry
//   o_mode       mode latched when ENTER is pressed in IDLE
//   o_digit      countdown digit 3..1, 0 outside COUNT
//   o_start      one-cycle pulse on the first PLAY cycle after COUNT
//   o_run        high only while in PLAY
//   o_loser      lowest-index player whose flag caused OVER
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module game_session_ctrl #(
    parameter int          NUM_MODES   = 2,
    parameter int          MODE_W      = 2,
    parameter int          NUM_PLAYERS = 2,
    parameter int          PLR_W       = 1,
    parameter int          COUNT_CYC   = 50_000_000,
    parameter int          COUNT_W     = 26,
    parameter logic [7:0]  KEY_UP      = 8'h75,
    parameter logic [7:0]  KEY_DOWN    = 8'h72,
    parameter logic [7:0]  KEY_ENTER   = 8'h5a,
    parameter logic [7:0]  KEY_ESC     = 8'h76,
    parameter logic [7:0]  KEY_PAUSE   = 8'h4d
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_key,
    input  logic [NUM_PLAYERS-1:0] i_game_over,
    output logic [2:0]             o_state,
    output logic [MODE_W-1:0]      o_cursor,
    output logic [MODE_W-1:0]      o_mode,
    output logic [1:0]             o_digit,
    output logic                   o_start,
    output logic                   o_run,
    output logic [PLR_W-1:0]       o_loser
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [MODE_W-1:0]  LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [COUNT_W-1:0] LAST_TICK = COUNT_W'(COUNT_CYC - 1);

    state_t              state_reg,    state_next;
    logic [MODE_W-1:0]   cursor_reg,   cursor_next;
    logic [MODE_W-1:0]   mode_reg,     mode_next;
    logic [1:0]          digit_reg,    digit_next;
    logic                start_reg,    start_next;
    logic                run_reg,      run_next;
    logic [PLR_W-1:0]    loser_reg,    loser_next;
    logic [7:0]          key_prev_reg;
    logic [COUNT_W-1:0]  tick_reg,     tick_next;

    // A key counts once when its code first appears; holding it produces
    // no further events, and releasing to 0 never counts.
    logic key_evt;
    logic up_evt, down_evt, enter_evt, esc_evt, pause_evt;

    assign key_evt   = (i_key != key_prev_reg) && (i_key != 8'h00);
    assign up_evt    = key_evt && (i_key == KEY_UP);
    assign down_evt  = key_evt && (i_key == KEY_DOWN);
    assign enter_evt = key_evt && (i_key == KEY_ENTER);
    assign esc_evt   = key_evt && (i_key == KEY_ESC);
    assign pause_evt = key_evt && (i_key == KEY_PAUSE);

    // Lowest set game-over index; scanning from the top lets the lowest
    // index overwrite the higher ones.
    logic             any_over;
    logic [PLR_W-1:0] over_idx;

    assign any_over = |i_game_over;

    always_comb begin
        over_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (i_game_over[i]) begin
                over_idx = PLR_W'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        mode_next   = mode_reg;
        digit_next  = 2'd0;
        start_next  = 1'b0;
        loser_next  = loser_reg;
        tick_next   = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (enter_evt) begin
                    mode_next  = cursor_reg;
                    digit_next = 2'd3;
                    state_next = ST_COUNT;
                end else if (up_evt) begin
                    cursor_next = (cursor_reg == '0) ? LAST_MODE : cursor_reg - 1'b1;
                end else if (down_evt) begin
                    cursor_next = (cursor_reg == LAST_MODE) ? '0 : cursor_reg + 1'b1;
                end
            end

            ST_COUNT: begin
                digit_next = digit_reg;
                if (esc_evt) begin
                    state_next = ST_IDLE;
                    digit_next = 2'd0;
                end else if (tick_reg == LAST_TICK) begin
                    if (digit_reg == 2'd1) begin
                        state_next = ST_PLAY;
                        digit_next = 2'd0;
                        start_next = 1'b1;
                    end else begin
                        digit_next = digit_reg - 2'd1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end

            ST_PLAY: begin
                if (any_over) begin
                    state_next = ST_OVER;
                    loser_next = over_idx;
                end else if (esc_evt) begin
                    state_next = ST_IDLE;
                end else if (pause_evt) begin
                    state_next = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (esc_evt) begin
                    state_next = ST_IDLE;
                end else if (pause_evt) begin
                    state_next = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (enter_evt || esc_evt) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Registered run enable mirrors the state being entered.
        run_next = (state_next == ST_PLAY);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            cursor_reg   <= '0;
            mode_reg     <= '0;
            digit_reg    <= 2'd0;
            start_reg    <= 1'b0;
            run_reg      <= 1'b0;
            loser_reg    <= '0;
            key_prev_reg <= 8'h00;
            tick_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cursor_reg   <= cursor_next;
            mode_reg     <= mode_next;
            digit_reg    <= digit_next;
            start_reg    <= start_next;
            run_reg      <= run_next;
            loser_reg    <= loser_next;
            key_prev_reg <= i_key;
            tick_reg     <= tick_next;
        end
    end

    assign o_state  = state_reg;
    assign o_cursor = cursor_reg;
    assign o_mode   = mode_reg;
    assign o_digit  = digit_reg;
    assign o_start  = start_reg;
    assign o_run    = run_reg;
    assign o_loser  = loser_reg;

endmodule

// File: tb/tb_game_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_session_ctrl
//
// Directed bench for game_session_ctrl with three modes, two players and a
// four-cycle countdown digit. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_game_session_ctrl;

    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_ENTER = 8'h5a;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_PAUSE = 8'h4d;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key = 8'h00;
    logic [1:0] game_over = 2'b00;
    logic [2:0] state;
    logic [1:0] cursor;
    logic [1:0] mode;
    logic [1:0] digit;
    logic       start;
    logic       run;
    logic [0:0] loser;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_session_ctrl #(
        .NUM_MODES   (3),
        .MODE_W      (2),
        .NUM_PLAYERS (2),
        .PLR_W       (1),
        .COUNT_CYC   (4),
        .COUNT_W     (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key       (key),
        .i_game_over (game_over),
        .o_state     (state),
        .o_cursor    (cursor),
        .o_mode      (mode),
        .o_digit     (digit),
        .o_start     (start),
        .o_run       (run),
        .o_loser     (loser)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Apply inputs for one cycle and return 1 time unit after the edge.
    task automatic step(input logic [7:0] k, input logic [1:0] go);
        key       = k;
        game_over = go;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"},  32'(state),  0);
        check({tag, ".cursor"}, 32'(cursor), 0);
        check({tag, ".mode"},   32'(mode),   0);
        check({tag, ".digit"},  32'(digit),  0);
        check({tag, ".start"},  32'(start),  0);
        check({tag, ".run"},    32'(run),    0);
        check({tag, ".loser"},  32'(loser),  0);
    endtask

    // From IDLE: ENTER, then let the 12-cycle countdown run into PLAY.
    task automatic enter_and_count(input string tag);
        step(K_ENTER, 2'b00);
        check({tag, ".count_state"}, 32'(state), 1);
        check({tag, ".count_digit0"}, 32'(digit), 3);
        for (int k = 1; k < 12; k++) begin
            step(8'h00, 2'b00);
            check($sformatf("%s.digit%0d", tag, k), 32'(digit), 32'(3 - k / 4));
            check($sformatf("%s.start%0d", tag, k), 32'(start), 0);
        end
        step(8'h00, 2'b00);
        check({tag, ".play_state"}, 32'(state), 2);
        check({tag, ".play_start"}, 32'(start), 1);
        check({tag, ".play_run"},   32'(run),   1);
        check({tag, ".play_digit"}, 32'(digit), 0);
        step(8'h00, 2'b00);
        check({tag, ".start_drop"}, 32'(start), 0);
        check({tag, ".run_hold"},   32'(run),   1);
    endtask

    initial begin
        // Reset
        step(8'h00, 2'b00);
        step(8'h00, 2'b00);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Held DOWN moves the cursor only once
        step(K_DOWN, 2'b00);
        check("down_first", 32'(cursor), 1);
        for (int k = 0; k < 9; k++) step(K_DOWN, 2'b00);
        check("down_held", 32'(cursor), 1);
        step(8'h00, 2'b00);
        step(K_DOWN, 2'b00);
        check("down_2", 32'(cursor), 2);
        step(8'h00, 2'b00);
        step(K_DOWN, 2'b00);
        check("down_wrap", 32'(cursor), 0);
        step(K_UP, 2'b00);
        check("up_wrap", 32'(cursor), 2);
        step(K_PAUSE, 2'b00);
        check("idle_pause_ign", 32'(state), 0);
        step(8'h00, 2'b00);

        // Countdown into PLAY with mode 2
        enter_and_count("cd1");
        check("mode_latched", 32'(mode), 2);

        // Pause, game-over ignored while paused, resume without start
        step(K_PAUSE, 2'b00);
        check("pause_state", 32'(state), 3);
        check("pause_run",   32'(run),   0);
        step(8'h00, 2'b01);
        check("pause_go_ign", 32'(state), 3);
        step(8'h00, 2'b00);
        step(K_PAUSE, 2'b00);
        check("resume_state", 32'(state), 2);
        check("resume_run",   32'(run),   1);
        check("resume_start", 32'(start), 0);
        step(8'h00, 2'b00);

        // Game over by player 1 only
        step(8'h00, 2'b10);
        check("over1_state", 32'(state), 4);
        check("over1_run",   32'(run),   0);
        check("over1_loser", 32'(loser), 1);
        step(8'h00, 2'b00);
        step(K_ENTER, 2'b00);
        check("over1_idle",   32'(state),  0);
        check("over1_cursor", 32'(cursor), 2);
        check("over1_mode",   32'(mode),   2);
        check("loser_held",   32'(loser),  1);
        step(8'h00, 2'b00);

        // ESC during countdown at digit 2
        step(K_ENTER, 2'b00);
        for (int k = 0; k < 4; k++) step(8'h00, 2'b00);
        check("mid_digit", 32'(digit), 2);
        step(K_ESC, 2'b00);
        check("esc_state", 32'(state), 0);
        check("esc_digit", 32'(digit), 0);
        check("esc_start", 32'(start), 0);
        step(8'h00, 2'b00);
        enter_and_count("cd2");

        // Game over on both players with ESC: game over wins, lowest index
        step(K_ESC, 2'b11);
        check("over2_state", 32'(state), 4);
        check("over2_loser", 32'(loser), 0);
        step(8'h00, 2'b00);
        step(K_ENTER, 2'b00);
        check("over2_idle",   32'(state),  0);
        check("over2_cursor", 32'(cursor), 2);
        check("over2_mode",   32'(mode),   2);
        step(8'h00, 2'b00);

        // Reset in the middle of PLAY, ENTER held across release
        enter_and_count("cd3");
        rst = 1'b1;
        step(K_ENTER, 2'b00);
        check_reset_outputs("rst_play");
        rst = 1'b0;
        step(K_ENTER, 2'b00);
        check("held_enter_state", 32'(state), 1);
        check("held_enter_mode",  32'(mode),  0);
        check("held_enter_digit", 32'(digit), 3);
        for (int k = 0; k < 3; k++) step(K_ENTER, 2'b00);
        check("held_enter_count", 32'(state), 1);
        check("held_enter_dig3",  32'(digit), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
